btn_debounce: RTL and testbench

- Conditions the raw `button` signal before it reaches the shift/segment display path.
- Synchronises the asynchronous pad input to `clk` and filters contact bounce with a counter-based FSM.
- Emits a one-cycle `btn_press` pulse that the downstream shift stage uses as its step enable, instead of clocking on the raw button.
- Also provides the debounced level, a release pulse and an 8-bit press counter for display or debug.

---
 rtl/btn_debounce.sv | 152 +++++++++++++++
 tb/tb_btn_debounce.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, counter-based debounce FSM, press/release pulses and press counter.
// Optional auto-repeat of btn_press while held is built only when BTN_REPEAT_EN is defined.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic [7:0] press_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHK_HI  = 2'd1,
        PRESSED = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    state_t        state, state_next, prev_state;
    logic [CW-1:0] cnt, cnt_next;
    logic          s1, s2;
    logic          level_d, press_d, release_d;
    logic          rpt_hit;

    // State register; prev_state lets the output stage recognise which transition just happened.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            state      <= IDLE;
            prev_state <= IDLE;
            cnt        <= '0;
        end else begin
            s1         <= button;
            s2         <= s1;
            state      <= state_next;
            prev_state <= state;
            cnt        <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_next = CHK_HI;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            CHK_HI: begin
                if (!s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_next = CHK_LO;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            CHK_LO: begin
                if (s2) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pulses fire only on the debounced transitions, never on a bounce back into PRESSED or IDLE.
    always_comb begin
        level_d   = (state == PRESSED) || (state == CHK_LO);
        press_d   = ((state == PRESSED) && (prev_state == CHK_HI)) || rpt_hit;
        release_d = (state == IDLE) && (prev_state == CHK_LO);
    end

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1) + 1;

    logic [RW-1:0] rpt_cnt;
    logic          rpt_armed;

    // rpt_cnt counts cycles spent in PRESSED; the first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    assign rpt_hit = (state == PRESSED) &&
                     (rpt_cnt == (rpt_armed ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (state != PRESSED) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_hit) begin
            rpt_cnt   <= RW'(1);
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            press_count <= 8'h00;
        end else begin
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            press_count <= press_count + 8'(press_d);
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: expected press/release events are queued with their due cycle when the button is
// driven, and a negedge monitor pops and compares them as the DUT pulses. Define BTN_REPEAT_EN for the repeat build.
module tb_btn_debounce;

    localparam int DB  = 8;
    localparam int RD  = 40;
    localparam int RP  = 10;
    localparam int LAT = DB + 3;  // drive at a negedge -> pulse seen at the negedge LAT cycles later
`ifdef BTN_REPEAT_EN
    localparam int REP_PULSES = 8;
`else
    localparam int REP_PULSES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic [7:0] press_count;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DB)
`ifdef BTN_REPEAT_EN
        ,
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .press_count(press_count)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // scoreboard
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_count = 8'h00;
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         rel_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (btn_press | btn_release)
                check_eq("pulse_exclusive", 32'(btn_press & btn_release), 32'd0);
            if (btn_press) begin
                if (exp_q.size() == 0) begin
                    check_eq("press_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("press_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                    check_eq("press_count", 32'(press_count), 32'(exp_q.pop_front()));
                end
            end
            if (btn_release) begin
                if (rel_q.size() == 0)
                    check_eq("release_expected", 32'(rel_q.size()), 32'd1);
                else
                    check_eq("release_cycle", 32'(cyc), 32'(rel_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_press(input int at);
        exp_count = exp_count + 8'h01;
        exp_q.push_back(exp_count);
        exp_cyc_q.push_back(at);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || rel_q.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_pending", 32'(exp_q.size() + rel_q.size()), 32'd0);
    endtask

    task automatic do_press();
        @(negedge clk);
        button = 1'b1;
        expect_press(cyc + LAT);
        drain(LAT + 5);
    endtask

    task automatic do_release();
        @(negedge clk);
        button = 1'b0;
        rel_q.push_back(cyc + LAT);
        drain(LAT + 5);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_level"}, 32'(btn_level), 32'd0);
        check_eq({tag, "_press"}, 32'(btn_press), 32'd0);
        check_eq({tag, "_release"}, 32'(btn_release), 32'd0);
        check_eq({tag, "_count"}, 32'(press_count), 32'd0);
    endtask

    int c;
    int base;

    initial begin
        rst    = 1'b0;
        button = 1'b1;
        wait_neg(3);
        check_reset_outputs("reset");

        // button held through reset: acceptance restarts from IDLE after release of rst
        rst = 1'b1;
        expect_press(cyc + LAT);
        drain(LAT + 5);
        check_eq("count_after_first", 32'(press_count), 32'd1);
        do_release();

        // clean press with level checks around both transitions
        @(negedge clk);
        c      = cyc;
        button = 1'b1;
        expect_press(c + LAT);
        wait_neg(LAT - 1);
        check_eq("clean_level_before", 32'(btn_level), 32'd0);
        wait_neg(1);
        check_eq("clean_level_after", 32'(btn_level), 32'd1);
        wait_neg(30 - LAT);
        c      = cyc;
        button = 1'b0;
        rel_q.push_back(c + LAT);
        wait_neg(LAT - 1);
        check_eq("clean_level_hold", 32'(btn_level), 32'd1);
        wait_neg(1);
        check_eq("clean_level_low", 32'(btn_level), 32'd0);
        drain(5);

        // bounce: 3-cycle toggles, ending low, then a clean rise
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            button = (i % 2 == 0);
            wait_neg(3);
        end
        check_eq("bounce_level", 32'(btn_level), 32'd0);
        c      = cyc;
        button = 1'b1;
        expect_press(c + LAT);
        drain(LAT + 5);
        check_eq("bounce_count", 32'(press_count), 32'd3);
        do_release();

        // short glitch of DB-1 cycles
        @(negedge clk);
        button = 1'b1;
        wait_neg(DB - 1);
        button = 1'b0;
        wait_neg(LAT + 5);
        check_eq("glitch_level", 32'(btn_level), 32'd0);
        check_eq("glitch_count", 32'(press_count), 32'(exp_count));

        // long hold: auto-repeat when built in
        base = 32'(press_count);
        @(negedge clk);
        c      = cyc;
        button = 1'b1;
        expect_press(c + LAT);
`ifdef BTN_REPEAT_EN
        for (int k = 0; k < 7; k++) expect_press(c + LAT + RD + k * RP);
`endif
        wait_neg(LAT + 101);
        button = 1'b0;
        rel_q.push_back(cyc + LAT);
        drain(LAT + 10);
        check_eq("repeat_count", 32'(8'(press_count - 8'(base))), 32'(REP_PULSES));

        // asynchronous reset while pressed, away from any clock edge
        do_press();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_count = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        expect_press(cyc + LAT);
        drain(LAT + 5);
        do_release();

        // wrap: 256 presses total since reset, then one more
        for (int n = 1; n < 256; n++) begin
            do_press();
            do_release();
        end
        check_eq("wrap_zero", 32'(press_count), 32'd0);
        do_press();
        check_eq("wrap_one", 32'(press_count), 32'd1);
        do_release();

        wait_neg(LAT);
        check_eq("final_queues", 32'(exp_q.size() + rel_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
